// File: rtl/i2s_rx_ctrl.sv
// I2S receiver controller: aligns to word select, deserialises left/right words
// and presents them as a ready/valid pair. Optional I2S_RX_OVERRUN_FLAG_EN adds a sticky overrun flag.
module i2s_rx_ctrl #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  sck_posedge_i,
    input  logic                  ws_i,
    input  logic                  sd_i,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] left_o,
    output logic [DATA_WIDTH-1:0] right_o,
    output logic                  valid_o
`ifdef I2S_RX_OVERRUN_FLAG_EN
    ,
    output logic                  overrun_o
`endif
);

    // state | meaning
    // IDLE  | receiver disabled
    // SYNC  | waiting for first WS 1->0 change to align on a frame
    // LEFT  | collecting left word
    // RIGHT | collecting right word; pair commits on next WS 1->0
    typedef enum logic [1:0] {IDLE, SYNC, LEFT, RIGHT} state_t;

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0]         CNT_MAX = CW'(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] MSB_ONE = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_t                state_q, state_d;
    logic                  ws_q, first_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] sr_q, sr_d, left_hold_q, left_hold_d, word_fin;
    logic                  ws_change, ws_rise, ws_fall, commit, handshake;

    assign ws_change = sck_posedge_i && !first_q && (ws_i != ws_q);
    assign ws_rise   = ws_change && ws_i;
    assign ws_fall   = ws_change && !ws_i;
    assign handshake = valid_o && ready_i;

    // Bit lands MSB-first at position cnt; once cnt saturates the mask is zero, dropping extra bits.
    assign word_fin = sd_i ? (sr_q | (MSB_ONE >> cnt_q)) : sr_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        left_hold_d = left_hold_q;
        commit      = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_i) state_d = SYNC;
            end
            SYNC: begin
                if (ws_fall) begin
                    state_d = LEFT;
                    cnt_d   = '0;
                    sr_d    = '0;
                end
            end
            LEFT: begin
                if (ws_rise) begin
                    state_d     = RIGHT;
                    left_hold_d = word_fin;
                    cnt_d       = '0;
                    sr_d        = '0;
                end else if (sck_posedge_i) begin
                    sr_d = word_fin;
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                end
            end
            RIGHT: begin
                if (ws_fall) begin
                    state_d = LEFT;
                    commit  = 1'b1;
                    cnt_d   = '0;
                    sr_d    = '0;
                end else if (sck_posedge_i) begin
                    sr_d = word_fin;
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!enable_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            sr_d    = '0;
            commit  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            ws_q        <= 1'b0;
            first_q     <= 1'b1;
            cnt_q       <= '0;
            sr_q        <= '0;
            left_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            left_hold_q <= left_hold_d;
            if (sck_posedge_i) begin
                ws_q    <= ws_i;
                first_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            left_o  <= '0;
            right_o <= '0;
            valid_o <= 1'b0;
`ifdef I2S_RX_OVERRUN_FLAG_EN
            overrun_o <= 1'b0;
`endif
        end else begin
`ifdef I2S_RX_OVERRUN_FLAG_EN
            // A pair that arrives while the previous one is still unaccepted is dropped.
            if (commit && (!valid_o || ready_i)) begin
                left_o  <= left_hold_q;
                right_o <= word_fin;
                valid_o <= 1'b1;
            end else begin
                if (commit) overrun_o <= 1'b1;
                if (handshake) valid_o <= 1'b0;
            end
            if (!enable_i) overrun_o <= 1'b0;
`else
            if (commit) begin
                left_o  <= left_hold_q;
                right_o <= word_fin;
                valid_o <= 1'b1;
            end else if (handshake) begin
                valid_o <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: doc/i2s_rx_ctrl.md
I2S_RX_CTRL -- requirements
Module: i2s_rx_ctrl

Interface
REQ-001 DATA_WIDTH, 16, bits stored per channel word (legal range 8..32).
REQ-002 clk_i  input  1  system clock; all logic on rising edge.
REQ-003 rst_i  input  1  asynchronous, active-low reset.
REQ-004 enable_i  input  1  receiver enable; low forces IDLE.
REQ-005 sck_posedge_i  input  1  one-clk_i strobe per synchronized SCK rising edge.
REQ-006 ws_i  input  1  synchronized word select; 0 = left, 1 = right.
REQ-007 sd_i  input  1  synchronized serial data; sampled only in strobe cycles.
REQ-008 ready_i  input  1  consumer accepts the pair when high with valid_o.
REQ-009 left_o  output  DATA_WIDTH  left sample of the presented pair.
REQ-010 right_o  output  DATA_WIDTH  right sample of the presented pair.
REQ-011 valid_o  output  1  pair available; held until the handshake completes.
REQ-012 overrun_o  output  1  sticky dropped-pair flag; present only with I2S_RX_OVERRUN_FLAG_EN.

Function
REQ-013 States: IDLE, SYNC, LEFT, RIGHT; IDLE->SYNC when enable_i=1; any state->IDLE in the cycle after enable_i=0.
REQ-014 On every strobe in every state: ws_q<=ws_i; a WS change is ws_i!=ws_q; detection is suppressed on the first strobe after reset.
REQ-015 SYNC->LEFT on a detected 1->0 change; SYNC ignores sd_i.
REQ-016 LEFT->RIGHT on a 0->1 change; RIGHT->LEFT on a 1->0 change; changes contrary to the current state are ignored.
REQ-017 The sd_i bit sampled on a change strobe is the last bit (LSB) of the outgoing word; the following strobes deliver the new word MSB first.
REQ-018 Bit counter is cleared at each channel start; the first DATA_WIDTH bits are stored; later bits are ignored; missing LSBs are zero-filled.
REQ-019 The pair commits on the RIGHT->LEFT change strobe; left_o, right_o and valid_o update in the next clk_i cycle (1-cycle latency).
REQ-020 While valid_o=1, left_o and right_o are stable; valid_o falls in the cycle after valid_o&&ready_i.
REQ-021 A commit in the same cycle as a completing handshake presents the new pair with no idle cycle.
REQ-022 Entering IDLE discards any partial pair; an already presented pair remains valid until accepted.

Reset
REQ-023 rst_i=0 asynchronously sets: state=IDLE; left_o=0; right_o=0; valid_o=0; overrun_o=0; counter=0; shift register=0; ws_q=0; detection suppressed.
REQ-024 Reset release requires no stimulus; operation starts at the first clk_i edge with rst_i=1.

Configuration
REQ-025 With I2S_RX_OVERRUN_FLAG_EN defined: a commit while valid_o=1 and ready_i=0 drops the new pair; presented outputs are unchanged; overrun_o<=1, sticky until reset or enable_i=0.
REQ-026 With I2S_RX_OVERRUN_FLAG_EN undefined: the port overrun_o is absent, and such a commit overwrites left_o/right_o; valid_o stays high.

Verification
REQ-027 DATA_WIDTH=16, 32-SCK frames, left 16'hA5C3, right 16'h3C5A, ready_i=1 -> second frame commits left_o=A5C3 and right_o=3C5A with valid_o high for 1 cycle, 1 cycle after the commit strobe.
REQ-028 ready_i=0 across two commits (pairs 1111/2222 then 3333/4444) -> with macro: outputs hold 1111/2222 and overrun_o=1; without macro: outputs show 3333/4444.
REQ-029 Left word of 12 bits, 12'hABC -> left_o=16'hABC0; 24-bit left word 24'h123456 -> left_o=16'h1234.
REQ-030 rst_i pulsed low mid-LEFT -> all outputs are 0 immediately; the first commit comes only after a fresh SYNC 1->0 change and a full frame.
REQ-031 enable_i=0 for 3 cycles mid-RIGHT with a pair pending -> pending pair is still accepted; the partial pair never appears; overrun_o is cleared.
REQ-032 Stream starts with ws_i=0 mid-word -> no commit until a 1->0 change is seen in SYNC.
